// File: rtl/cp0_except_ctrl_pkg.sv
// Shared constants and types for the MEM-stage exception sequencer.
package cp0_except_ctrl_pkg;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    // ExcCode values as presented to CP0 on excepttype_o
    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_TR   = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_BUS,
        ST_COMMIT,
        ST_REDIRECT
    } exc_state_t;

    // Per-instruction exception flags carried down to MEM
    typedef struct packed {
        logic adel_if;
        logic ri;
        logic ov;
        logic trap;
        logic sys;
        logic brk;
        logic adel;
        logic ades;
        logic eret;
    } exc_flags_t;

    // Interrupt is pending when IE=1, EXL=0 and any unmasked IP bit is set
    function automatic logic int_pending(input logic [31:0] status, input logic [31:0] cause);
        return status[0] & ~status[1] & (|(status[15:8] & cause[15:8]));
    endfunction

endpackage

// File: rtl/cp0_except_ctrl_if.sv
// MEM-stage exception bus: pipeline/CP0 inputs and the commit/redirect outputs.
interface cp0_except_ctrl_if;

    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_in_delayslot;
    logic        mem_adel_if;
    logic        mem_ri;
    logic        mem_ov;
    logic        mem_trap;
    logic        mem_sys;
    logic        mem_brk;
    logic        mem_adel;
    logic        mem_ades;
    logic        mem_eret;
    logic [31:0] mem_daddr;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
    logic        dbus_busy;
    logic        if_ready;

    logic [31:0] excepttype_o;
    logic [31:0] current_inst_addr_o;
    logic        is_in_delayslot_o;
    logic [31:0] bad_addr_o;
    logic        flush_o;
    logic        stall_o;
    logic        redirect_valid_o;
    logic [31:0] new_pc_o;

    // Pipeline / CP0 side
    modport master (
        output mem_valid, mem_pc, mem_in_delayslot, mem_adel_if, mem_ri, mem_ov,
               mem_trap, mem_sys, mem_brk, mem_adel, mem_ades, mem_eret, mem_daddr,
               status_i, cause_i, epc_i, dbus_busy, if_ready,
        input  excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o,
               flush_o, stall_o, redirect_valid_o, new_pc_o
    );

    // Exception controller side
    modport slave (
        input  mem_valid, mem_pc, mem_in_delayslot, mem_adel_if, mem_ri, mem_ov,
               mem_trap, mem_sys, mem_brk, mem_adel, mem_ades, mem_eret, mem_daddr,
               status_i, cause_i, epc_i, dbus_busy, if_ready,
        output excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o,
               flush_o, stall_o, redirect_valid_o, new_pc_o
    );

endinterface

// File: rtl/cp0_except_ctrl_exc_prio_enc.sv
// Fixed-priority exception encoder: flags + interrupt -> ExcCode and BadVAddr.
module exc_prio_enc
    import cp0_except_ctrl_pkg::*;
(
    input  logic        int_pend,
    input  exc_flags_t  flags,
    input  logic [31:0] pc,
    input  logic [31:0] daddr,
    output logic        hit,
    output logic        is_eret,
    output logic [31:0] code,
    output logic [31:0] badaddr
);

    // Highest-priority source wins; interrupts outrank every synchronous cause
    always_comb begin
        code    = 32'h0;
        badaddr = 32'h0;
        is_eret = 1'b0;
        hit     = 1'b1;
        if (int_pend) begin
            code = EXC_INT;
        end else if (flags.adel_if) begin
            code    = EXC_ADEL;
            badaddr = pc;
        end else if (flags.ri) begin
            code = EXC_RI;
        end else if (flags.ov) begin
            code = EXC_OV;
        end else if (flags.trap) begin
            code = EXC_TR;
        end else if (flags.sys) begin
            code = EXC_SYS;
        end else if (flags.brk) begin
            code = EXC_BP;
        end else if (flags.adel) begin
            code    = EXC_ADEL;
            badaddr = daddr;
        end else if (flags.ades) begin
            code    = EXC_ADES;
            badaddr = daddr;
        end else if (flags.eret) begin
            code    = EXC_ERET;
            is_eret = 1'b1;
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/cp0_except_ctrl.sv
// MEM-stage exception sequencer: picks one event, pulses it into CP0 once,
// then flushes and holds a PC redirect until fetch takes it.
module cp0_except_ctrl
    import cp0_except_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic             clk,
    input  logic             resetn,
    cp0_except_ctrl_if.slave bus
);

    exc_flags_t  flags;
    logic        int_pend;
    logic        enc_hit;
    logic        enc_eret;
    logic [31:0] enc_code;
    logic [31:0] enc_bad;
    logic        event_now;
    logic [31:0] target;

    exc_state_t  state;

    // Values frozen when the event is taken; never re-sampled while waiting
    logic [31:0] cap_code;
    logic [31:0] cap_pc;
    logic        cap_ds;
    logic [31:0] cap_bad;
    logic [31:0] cap_target;

    logic [31:0] exc_r;
    logic [31:0] addr_r;
    logic        ds_r;
    logic [31:0] bad_r;
    logic        flush_r;
    logic        stall_r;
    logic        rv_r;
    logic [31:0] npc_r;

    assign flags = '{
        adel_if: bus.mem_adel_if,
        ri:      bus.mem_ri,
        ov:      bus.mem_ov,
        trap:    bus.mem_trap,
        sys:     bus.mem_sys,
        brk:     bus.mem_brk,
        adel:    bus.mem_adel,
        ades:    bus.mem_ades,
        eret:    bus.mem_eret
    };

    assign int_pend = int_pending(bus.status_i, bus.cause_i);

    exc_prio_enc u_prio (
        .int_pend (int_pend),
        .flags    (flags),
        .pc       (bus.mem_pc),
        .daddr    (bus.mem_daddr),
        .hit      (enc_hit),
        .is_eret  (enc_eret),
        .code     (enc_code),
        .badaddr  (enc_bad)
    );

    // An interrupt alone cannot fire on a bubble; it waits for a live instruction
    assign event_now = bus.mem_valid & enc_hit;
    assign target    = enc_eret ? bus.epc_i : EXC_VECTOR;

    // Sequencer: capture -> (wait for bus) -> one-cycle CP0 pulse -> hold redirect
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            cap_code   <= 32'h0;
            cap_pc     <= 32'h0;
            cap_ds     <= 1'b0;
            cap_bad    <= 32'h0;
            cap_target <= 32'h0;
            exc_r      <= 32'h0;
            addr_r     <= 32'h0;
            ds_r       <= 1'b0;
            bad_r      <= 32'h0;
            flush_r    <= 1'b0;
            stall_r    <= 1'b0;
            rv_r       <= 1'b0;
            npc_r      <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (event_now) begin
                        cap_code   <= enc_code;
                        cap_pc     <= bus.mem_pc;
                        cap_ds     <= bus.mem_in_delayslot;
                        cap_bad    <= enc_bad;
                        cap_target <= target;
                        if (bus.dbus_busy) begin
                            state   <= ST_WAIT_BUS;
                            stall_r <= 1'b1;
                        end else begin
                            state   <= ST_COMMIT;
                            exc_r   <= enc_code;
                            addr_r  <= bus.mem_pc;
                            ds_r    <= bus.mem_in_delayslot;
                            bad_r   <= enc_bad;
                            flush_r <= 1'b1;
                            rv_r    <= 1'b1;
                            npc_r   <= target;
                        end
                    end
                end
                ST_WAIT_BUS: begin
                    if (!bus.dbus_busy) begin
                        state   <= ST_COMMIT;
                        stall_r <= 1'b0;
                        exc_r   <= cap_code;
                        addr_r  <= cap_pc;
                        ds_r    <= cap_ds;
                        bad_r   <= cap_bad;
                        flush_r <= 1'b1;
                        rv_r    <= 1'b1;
                        npc_r   <= cap_target;
                    end
                end
                ST_COMMIT: begin
                    // CP0 fields are a single-cycle pulse
                    exc_r  <= 32'h0;
                    addr_r <= 32'h0;
                    ds_r   <= 1'b0;
                    bad_r  <= 32'h0;
                    if (bus.if_ready) begin
                        state   <= ST_IDLE;
                        flush_r <= 1'b0;
                        rv_r    <= 1'b0;
                        npc_r   <= 32'h0;
                    end else begin
                        state <= ST_REDIRECT;
                    end
                end
                ST_REDIRECT: begin
                    if (bus.if_ready) begin
                        state   <= ST_IDLE;
                        flush_r <= 1'b0;
                        rv_r    <= 1'b0;
                        npc_r   <= 32'h0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.excepttype_o        = exc_r;
    assign bus.current_inst_addr_o = addr_r;
    assign bus.is_in_delayslot_o   = ds_r;
    assign bus.bad_addr_o          = bad_r;
    assign bus.flush_o             = flush_r;
    assign bus.stall_o             = stall_r;
    assign bus.redirect_valid_o    = rv_r;
    assign bus.new_pc_o            = npc_r;

endmodule

// File: tb/tb_cp0_except_ctrl.sv
// Directed bench for cp0_except_ctrl; expected values are hand-derived constants.
module tb_cp0_except_ctrl;

    logic clk;
    logic resetn;
    int   n_cmp;
    int   n_bad;

    cp0_except_ctrl_if bus ();

    cp0_except_ctrl #(.EXC_VECTOR(32'hBFC0_0380)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then read 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        bus.mem_valid        = 1'b0;
        bus.mem_pc           = 32'h0;
        bus.mem_in_delayslot = 1'b0;
        bus.mem_adel_if      = 1'b0;
        bus.mem_ri           = 1'b0;
        bus.mem_ov           = 1'b0;
        bus.mem_trap         = 1'b0;
        bus.mem_sys          = 1'b0;
        bus.mem_brk          = 1'b0;
        bus.mem_adel         = 1'b0;
        bus.mem_ades         = 1'b0;
        bus.mem_eret         = 1'b0;
        bus.mem_daddr        = 32'h0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".exc"},   bus.excepttype_o, 32'h0);
        chk({tag, ".flush"}, {31'h0, bus.flush_o}, 32'h0);
        chk({tag, ".rv"},    {31'h0, bus.redirect_valid_o}, 32'h0);
        chk({tag, ".stall"}, {31'h0, bus.stall_o}, 32'h0);
        chk({tag, ".npc"},   bus.new_pc_o, 32'h0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        resetn = 1'b0;
        clear_mem();
        bus.status_i  = 32'h0;
        bus.cause_i   = 32'h0;
        bus.epc_i     = 32'h0;
        bus.dbus_busy = 1'b0;
        bus.if_ready  = 1'b1;
        tick();
        tick();
        chk_quiet("rst");
        chk("rst.addr", bus.current_inst_addr_o, 32'h0);
        chk("rst.bad",  bus.bad_addr_o, 32'h0);

        // live instruction, no flags: nothing happens
        resetn = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_pc = 32'hBFC0_0000;
        tick();
        chk_quiet("noflag");

        // 1: overflow, bus idle, fetch ready
        bus.mem_ov = 1'b1;
        bus.mem_pc = 32'hBFC0_0100;
        tick();
        chk("t1.exc",   bus.excepttype_o, 32'h0C);
        chk("t1.addr",  bus.current_inst_addr_o, 32'hBFC0_0100);
        chk("t1.flush", {31'h0, bus.flush_o}, 32'h1);
        chk("t1.rv",    {31'h0, bus.redirect_valid_o}, 32'h1);
        chk("t1.npc",   bus.new_pc_o, 32'hBFC0_0380);
        chk("t1.bad",   bus.bad_addr_o, 32'h0);
        clear_mem();
        tick();
        chk_quiet("t1.after");

        // 2: adel_if beats ri and sys
        bus.mem_valid   = 1'b1;
        bus.mem_adel_if = 1'b1;
        bus.mem_ri      = 1'b1;
        bus.mem_sys     = 1'b1;
        bus.mem_pc      = 32'hBFC0_0102;
        tick();
        chk("t2.exc", bus.excepttype_o, 32'h04);
        chk("t2.bad", bus.bad_addr_o, 32'hBFC0_0102);
        clear_mem();
        tick();

        // trap beats sys/brk; delay-slot flag carried through
        bus.mem_valid = 1'b1;
        bus.mem_trap = 1'b1;
        bus.mem_sys = 1'b1;
        bus.mem_brk = 1'b1;
        bus.mem_in_delayslot = 1'b1;
        bus.mem_pc = 32'hBFC0_0204;
        tick();
        chk("tr.exc", bus.excepttype_o, 32'h0D);
        chk("tr.ds",  {31'h0, bus.is_in_delayslot_o}, 32'h1);
        chk("tr.addr", bus.current_inst_addr_o, 32'hBFC0_0204);
        clear_mem();
        tick();

        // load AdE beats store AdE; badaddr from data address
        bus.mem_valid = 1'b1;
        bus.mem_adel = 1'b1;
        bus.mem_ades = 1'b1;
        bus.mem_daddr = 32'h8000_0011;
        bus.mem_pc = 32'hBFC0_0300;
        tick();
        chk("adel.exc", bus.excepttype_o, 32'h04);
        chk("adel.bad", bus.bad_addr_o, 32'h8000_0011);
        clear_mem();
        tick();

        // 3: interrupt pending, but bubble in MEM -> nothing
        bus.status_i = 32'h0000_0401;
        bus.cause_i  = 32'h0000_0400;
        tick();
        chk_quiet("int.bubble");
        bus.mem_valid = 1'b1;
        bus.mem_sys = 1'b1;
        bus.mem_pc = 32'hBFC0_0400;
        tick();
        chk("t3.exc", bus.excepttype_o, 32'h01);
        chk("t3.npc", bus.new_pc_o, 32'hBFC0_0380);
        clear_mem();
        tick();
        bus.status_i = 32'h0000_0403;
        bus.mem_valid = 1'b1;
        bus.mem_sys = 1'b1;
        tick();
        chk("t3.exl.exc", bus.excepttype_o, 32'h08);
        clear_mem();
        bus.status_i = 32'h0;
        bus.cause_i = 32'h0;
        tick();

        // 4: store AdE while bus busy for 3 edges
        bus.mem_valid = 1'b1;
        bus.mem_ades = 1'b1;
        bus.mem_daddr = 32'h8000_0003;
        bus.mem_pc = 32'hBFC0_0500;
        bus.dbus_busy = 1'b1;
        tick();
        chk("t4.s0", {31'h0, bus.stall_o}, 32'h1);
        chk("t4.e0", bus.excepttype_o, 32'h0);
        // different flags now must not be re-sampled
        bus.mem_ades = 1'b0;
        bus.mem_ov = 1'b1;
        bus.mem_daddr = 32'h0;
        tick();
        chk("t4.s1", {31'h0, bus.stall_o}, 32'h1);
        chk("t4.e1", bus.excepttype_o, 32'h0);
        tick();
        chk("t4.s2", {31'h0, bus.stall_o}, 32'h1);
        chk("t4.e2", bus.excepttype_o, 32'h0);
        bus.dbus_busy = 1'b0;
        clear_mem();
        tick();
        chk("t4.exc",   bus.excepttype_o, 32'h05);
        chk("t4.bad",   bus.bad_addr_o, 32'h8000_0003);
        chk("t4.addr",  bus.current_inst_addr_o, 32'hBFC0_0500);
        chk("t4.stall", {31'h0, bus.stall_o}, 32'h0);
        tick();
        chk_quiet("t4.after");

        // 5: ERET with fetch not ready for 2 edges
        bus.mem_valid = 1'b1;
        bus.mem_eret = 1'b1;
        bus.epc_i = 32'hBFC0_0200;
        bus.if_ready = 1'b0;
        tick();
        chk("t5.exc", bus.excepttype_o, 32'h0E);
        chk("t5.npc", bus.new_pc_o, 32'hBFC0_0200);
        clear_mem();
        tick();
        chk("t5.r1.exc", bus.excepttype_o, 32'h0);
        chk("t5.r1.rv",  {31'h0, bus.redirect_valid_o}, 32'h1);
        chk("t5.r1.fl",  {31'h0, bus.flush_o}, 32'h1);
        chk("t5.r1.npc", bus.new_pc_o, 32'hBFC0_0200);
        tick();
        chk("t5.r2.rv",  {31'h0, bus.redirect_valid_o}, 32'h1);
        chk("t5.r2.npc", bus.new_pc_o, 32'hBFC0_0200);
        bus.if_ready = 1'b1;
        tick();
        chk_quiet("t5.after");

        // 6: reset while holding redirect
        bus.if_ready = 1'b0;
        bus.mem_valid = 1'b1;
        bus.mem_brk = 1'b1;
        bus.mem_pc = 32'hBFC0_0600;
        tick();
        chk("t6.exc", bus.excepttype_o, 32'h09);
        clear_mem();
        tick();
        chk("t6.rv", {31'h0, bus.redirect_valid_o}, 32'h1);
        resetn = 1'b0;
        tick();
        chk_quiet("t6.rst");
        resetn = 1'b1;
        tick();
        chk_quiet("t6.post1");
        tick();
        chk_quiet("t6.post2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
